// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transceiver.
//   tx_state_t / rx_state_t : FSM state encodings for the TX and RX paths.
//   frame_bits()            : number of bit periods in one transmitted frame.
//   parity_bit()            : parity bit value for a data word (even or odd).
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  function automatic int frame_bits(input int n, input int parity_en, input int stop_bits);
    return 1 + n + parity_en + stop_bits;
  endfunction

  // Data is zero-extended to 16 bits by the caller; the extra zeros do not
  // change the XOR reduction.
  function automatic logic parity_bit(input logic [15:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_transceiver_if.sv
// uart_transceiver_if: byte-stream and serial-pin bundle of the transceiver.
//   tx_data/tx_valid/tx_ready : transmit word handshake (accept = valid & ready)
//   txd / rxd                 : serial output / asynchronous serial input
//   rx_data/rx_valid          : received word and its one-cycle completion pulse
//   rx_parity_err/rx_frame_err: error status of the last received frame
// Modport slave is the transceiver side; master is the producer/consumer side.
interface uart_transceiver_if #(
  parameter int N = 8
);
  logic [N-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         txd;
  logic         rxd;
  logic [N-1:0] rx_data;
  logic         rx_valid;
  logic         rx_parity_err;
  logic         rx_frame_err;

  modport master (
    output tx_data, tx_valid, rxd,
    input  tx_ready, txd, rx_data, rx_valid, rx_parity_err, rx_frame_err
  );

  modport slave (
    input  tx_data, tx_valid, rxd,
    output tx_ready, txd, rx_data, rx_valid, rx_parity_err, rx_frame_err
  );
endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period counter for one UART direction.
//   clk    : clock
//   rst    : synchronous active-low reset
//   clr_i  : hold the counter at 0 (idle)
//   half_i : preload so the first tick arrives CLKS_PER_BIT/2 cycles later
//   tick_o : high in the last cycle of each bit period
// half_i takes priority over clr_i so the RX FSM can request the half-bit
// preload while it is still in IDLE.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic half_i,
  output logic tick_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT - CLKS_PER_BIT / 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (half_i) begin
      cnt_d = HALF_LOAD;
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex UART, independent TX and RX sharing one clock.
//   clk : clock
//   rst : synchronous active-low reset
//   bus : uart_transceiver_if.slave (tx_data/tx_valid/tx_ready, txd, rxd,
//         rx_data/rx_valid, rx_parity_err, rx_frame_err)
// Parameters: N data bits (LSB first), CLKS_PER_BIT (>= 4), PARITY_EN,
// PARITY_ODD, STOP_BITS (1 or 2, receiver checks only the first).
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input logic                  clk,
  input logic                  rst,
  uart_transceiver_if.slave    bus
);
  localparam int   IW  = $clog2(N);
  localparam logic ODD = (PARITY_ODD != 0);
  localparam logic PEN = (PARITY_EN != 0);

  // ---------------------------------------------------------------- TX path
  tx_state_t    tx_state_q, tx_state_d;
  logic [N-1:0] tx_shift_q, tx_shift_d;
  logic [IW-1:0] tx_idx_q, tx_idx_d;
  logic         tx_par_q, tx_par_d;
  logic         txd_q, txd_d;
  logic         tx_tick;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tx_state_q == TX_IDLE),
    .half_i (1'b0),
    .tick_o (tx_tick)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_idx_d   = tx_idx_q;
    tx_par_d   = tx_par_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (bus.tx_valid) begin
          tx_state_d = TX_START;
          tx_shift_d = bus.tx_data;
          tx_par_d   = parity_bit(16'(bus.tx_data), ODD);
          tx_idx_d   = '0;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_state_d = TX_DATA;
          tx_idx_d   = '0;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          if (tx_idx_q == IW'(N - 1)) begin
            tx_idx_d   = '0;
            tx_state_d = PEN ? TX_PARITY : TX_STOP;
          end else begin
            tx_idx_d   = tx_idx_q + 1'b1;
            tx_shift_d = tx_shift_q >> 1;
          end
        end
      end
      TX_PARITY: begin
        if (tx_tick) begin
          tx_state_d = TX_STOP;
          tx_idx_d   = '0;
        end
      end
      TX_STOP: begin
        // The bit index doubles as the stop-bit counter.
        if (tx_tick) begin
          if (tx_idx_q == IW'(STOP_BITS - 1)) begin
            tx_state_d = TX_IDLE;
            tx_idx_d   = '0;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // txd is registered from the next state so the line changes on the same
    // edge as the state, giving the 1-cycle accept-to-start latency.
    case (tx_state_d)
      TX_START:  txd_d = 1'b0;
      TX_DATA:   txd_d = tx_shift_d[0];
      TX_PARITY: txd_d = tx_par_q;
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      tx_idx_q   <= '0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_idx_q   <= tx_idx_d;
      tx_par_q   <= tx_par_d;
      txd_q      <= txd_d;
    end
  end

  assign bus.tx_ready = (tx_state_q == TX_IDLE);
  assign bus.txd      = txd_q;

  // ---------------------------------------------------------------- RX path
  logic          rx_meta_q, rxs_q;
  rx_state_t     rx_state_q, rx_state_d;
  logic [N-1:0]  rx_shift_q, rx_shift_d;
  logic [IW-1:0] rx_idx_q, rx_idx_d;
  logic          rx_par_q, rx_par_d;
  logic [N-1:0]  rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_perr_q, rx_perr_d;
  logic          rx_ferr_q, rx_ferr_d;
  logic          rx_tick;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= bus.rxd;
      rxs_q     <= rx_meta_q;
    end
  end

  // In IDLE a low line preloads the timer so the start bit is re-checked
  // half a bit later; every later sample is one full bit period apart.
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (rx_state_q == RX_IDLE),
    .half_i ((rx_state_q == RX_IDLE) && !rxs_q),
    .tick_o (rx_tick)
  );

  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_idx_d   = rx_idx_q;
    rx_par_d   = rx_par_q;
    rx_data_d  = rx_data_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_valid_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rxs_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_tick) begin
          // A line that is high again at mid-start was a glitch.
          rx_state_d = rxs_q ? RX_IDLE : RX_DATA;
          rx_idx_d   = '0;
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_shift_d = {rxs_q, rx_shift_q[N-1:1]};
          if (rx_idx_q == IW'(N - 1)) begin
            rx_idx_d   = '0;
            rx_state_d = PEN ? RX_PARITY : RX_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (rx_tick) begin
          rx_par_d   = rxs_q;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          rx_state_d = RX_IDLE;
          rx_data_d  = rx_shift_q;
          rx_perr_d  = PEN & (parity_bit(16'(rx_shift_q), ODD) ^ rx_par_q);
          rx_ferr_d  = !rxs_q;
          rx_valid_d = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state_q <= RX_IDLE;
      rx_shift_q <= '0;
      rx_idx_q   <= '0;
      rx_par_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_idx_q   <= rx_idx_d;
      rx_par_q   <= rx_par_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.rx_parity_err = rx_perr_q;
  assign bus.rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Testbench for uart_transceiver: a default instance (dut0) and an even-parity
// instance (dut1). Each rxd is either looped back from its own txd or driven
// by the bench. Received words are checked against a per-instance queue.
module tb_uart_transceiver;
  import uart_pkg::*;

  localparam int C = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;

  logic [1:0] tb_rxd   = 2'b11;
  logic [1:0] line_sel = 2'b11;   // 1: bench drives rxd, 0: loopback

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_transceiver_if #(.N(8)) bus0 ();
  uart_transceiver_if #(.N(8)) bus1 ();

  assign bus0.rxd = line_sel[0] ? tb_rxd[0] : bus0.txd;
  assign bus1.rxd = line_sel[1] ? tb_rxd[1] : bus1.txd;

  uart_transceiver #(.N(8), .CLKS_PER_BIT(C)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  uart_transceiver #(.N(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ------------------------------------------------------------ scoreboard
  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rx_exp_t;

  rx_exp_t q0[$];
  rx_exp_t q1[$];
  rx_exp_t e0, e1;
  int      t_rxv0 = -1;
  logic    pv0 = 1'b0;
  logic    pv1 = 1'b0;

  always @(negedge clk) begin
    if (pv0) chk("rx0_pulse_width", 32'(bus0.rx_valid), 0);
    pv0 = (bus0.rx_valid === 1'b1);
    if (bus0.rx_valid === 1'b1) begin
      t_rxv0 = cyc;
      if (q0.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL rx0_unexpected: got rx_valid with data 0x%0h, required no output", bus0.rx_data);
      end else begin
        e0 = q0.pop_front();
        chk("rx0_data", 32'(bus0.rx_data), 32'(e0.data));
        chk("rx0_perr", 32'(bus0.rx_parity_err), 32'(e0.perr));
        chk("rx0_ferr", 32'(bus0.rx_frame_err), 32'(e0.ferr));
      end
    end
  end

  always @(negedge clk) begin
    if (pv1) chk("rx1_pulse_width", 32'(bus1.rx_valid), 0);
    pv1 = (bus1.rx_valid === 1'b1);
    if (bus1.rx_valid === 1'b1) begin
      if (q1.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL rx1_unexpected: got rx_valid with data 0x%0h, required no output", bus1.rx_data);
      end else begin
        e1 = q1.pop_front();
        chk("rx1_data", 32'(bus1.rx_data), 32'(e1.data));
        chk("rx1_perr", 32'(bus1.rx_parity_err), 32'(e1.perr));
        chk("rx1_ferr", 32'(bus1.rx_frame_err), 32'(e1.ferr));
      end
    end
  end

  // Bench-generated frame on tb_rxd[inst]; call at a negedge.
  task automatic drive_frame(input int inst, input logic [7:0] d, input logic pen,
                             input logic pbit, input logic stopv);
    int   nb;
    logic v;
    nb = pen ? 11 : 10;
    for (int b = 0; b < nb; b++) begin
      if (b == 0)             v = 1'b0;
      else if (b <= 8)        v = d[b-1];
      else if (pen && b == 9) v = pbit;
      else                    v = stopv;
      tb_rxd[inst] = v;
      repeat (C) @(negedge clk);
    end
    tb_rxd[inst] = 1'b1;
    repeat (2 * C) @(negedge clk);
  endtask

  // ------------------------------------------------------------ vectors
  typedef struct {
    int         inst;
    logic [7:0] d;
    logic       pbit;
    logic       stopv;
    logic [7:0] exp_d;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];

  logic [9:0]  fb0;
  logic [10:0] fb1;
  int          t_fall, t_fall2, low_cnt;

  initial begin
    vecs[0] = '{0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};  // stop held low
    vecs[1] = '{0, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};  // clean frame clears flag
    vecs[2] = '{1, 8'h2B, 1'b0, 1'b1, 8'h2B, 1'b0, 1'b0};  // correct even parity
    vecs[3] = '{1, 8'h2B, 1'b1, 1'b1, 8'h2B, 1'b1, 1'b0};  // parity forced to 1
    vecs[4] = '{1, 8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};  // good parity, bad stop
    vecs[5] = '{0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};

    bus0.tx_valid = 1'b0;
    bus0.tx_data  = '0;
    bus1.tx_valid = 1'b0;
    bus1.tx_data  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(bus0.txd), 1);
    chk("rst_tx_ready", 32'(bus0.tx_ready), 1);
    chk("rst_rx_valid", 32'(bus0.rx_valid), 0);
    chk("rst_rx_data", 32'(bus0.rx_data), 0);
    chk("rst_perr", 32'(bus0.rx_parity_err), 0);
    chk("rst_ferr", 32'(bus0.rx_frame_err), 0);
    chk("rst_rx1_data", 32'(bus1.rx_data), 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Table-driven bench frames into both receivers
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].inst == 0) q0.push_back('{vecs[i].exp_d, vecs[i].exp_perr, vecs[i].exp_ferr});
      else                   q1.push_back('{vecs[i].exp_d, vecs[i].exp_perr, vecs[i].exp_ferr});
      drive_frame(vecs[i].inst, vecs[i].d, vecs[i].inst == 1, vecs[i].pbit, vecs[i].stopv);
    end

    // 4-cycle low glitch: false start, then a real frame
    tb_rxd[0] = 1'b0;
    repeat (4) @(negedge clk);
    tb_rxd[0] = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_rx_idle", 32'(dut0.rx_state_q), 32'(RX_IDLE));
    chk("glitch_data_held", 32'(bus0.rx_data), 32'h00);
    q0.push_back('{8'h5A, 1'b0, 1'b0});
    drive_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);

    // Loopback 0xA5 on dut0: line bits, frame length, RX latency
    line_sel[0] = 1'b0;
    fb0 = {1'b1, 8'hA5, 1'b0};
    q0.push_back('{8'hA5, 1'b0, 1'b0});
    t_rxv0 = -1;
    @(negedge clk);
    bus0.tx_data  = 8'hA5;
    bus0.tx_valid = 1'b1;
    @(posedge clk);
    #1 bus0.tx_valid = 1'b0;
    for (int j = 0; j < 10 * C; j++) begin
      @(negedge clk);
      if (j == 0) begin
        t_fall = cyc;
        chk("a5_start_low", 32'(bus0.txd), 0);
        chk("a5_ready_drop", 32'(bus0.tx_ready), 0);
      end
      if (j % C == C / 2) chk("a5_txd_bit", 32'(bus0.txd), 32'(fb0[j / C]));
      if (j == 10 * C - 1) chk("a5_ready_last", 32'(bus0.tx_ready), 0);
    end
    @(negedge clk);
    chk("a5_ready_back", 32'(bus0.tx_ready), 1);
    chk("a5_latency", t_rxv0 - t_fall, 155);
    repeat (10) @(negedge clk);

    // Parity loopback 0x2B on dut1: parity bit 0 on the line
    line_sel[1] = 1'b0;
    fb1 = {1'b1, 1'b0, 8'h2B, 1'b0};
    q1.push_back('{8'h2B, 1'b0, 1'b0});
    @(negedge clk);
    bus1.tx_data  = 8'h2B;
    bus1.tx_valid = 1'b1;
    @(posedge clk);
    #1 bus1.tx_valid = 1'b0;
    for (int j = 0; j < 11 * C; j++) begin
      @(negedge clk);
      if (j % C == C / 2) chk("p2b_txd_bit", 32'(bus1.txd), 32'(fb1[j / C]));
    end
    repeat (20) @(negedge clk);

    // Back-to-back 0x11 / 0x22 with tx_valid held high
    q0.push_back('{8'h11, 1'b0, 1'b0});
    q0.push_back('{8'h22, 1'b0, 1'b0});
    @(negedge clk);
    bus0.tx_data  = 8'h11;
    bus0.tx_valid = 1'b1;
    @(posedge clk);
    #1 bus0.tx_data = 8'h22;
    @(negedge clk);
    t_fall = cyc;
    chk("b2b_first_start", 32'(bus0.txd), 0);
    low_cnt = 0;
    while (bus0.tx_ready !== 1'b1 && low_cnt < 400) begin
      low_cnt++;
      @(negedge clk);
    end
    chk("b2b_ready_low_cycles", low_cnt, 160);
    @(posedge clk);
    #1 bus0.tx_valid = 1'b0;
    @(negedge clk);
    t_fall2 = cyc;
    chk("b2b_second_start", 32'(bus0.txd), 0);
    chk("b2b_start_spacing", t_fall2 - t_fall, 161);
    repeat (200) @(negedge clk);

    // Reset mid-TX and mid-RX (0x77 is discarded)
    @(negedge clk);
    bus0.tx_data  = 8'h77;
    bus0.tx_valid = 1'b1;
    @(posedge clk);
    #1 bus0.tx_valid = 1'b0;
    repeat (60) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_txd", 32'(bus0.txd), 1);
    chk("mid_rst_tx_ready", 32'(bus0.tx_ready), 1);
    chk("mid_rst_rx_valid", 32'(bus0.rx_valid), 0);
    chk("mid_rst_rx_idle", 32'(dut0.rx_state_q), 32'(RX_IDLE));
    rst = 1'b1;
    repeat (250) @(negedge clk);

    // Exchange after reset: loopback on dut0, bench frame into dut1
    line_sel[1] = 1'b1;
    q0.push_back('{8'hC5, 1'b0, 1'b0});
    q1.push_back('{8'hC5, 1'b0, 1'b0});
    @(negedge clk);
    bus0.tx_data  = 8'hC5;
    bus0.tx_valid = 1'b1;
    @(posedge clk);
    #1 bus0.tx_valid = 1'b0;
    @(negedge clk);
    drive_frame(1, 8'hC5, 1'b1, 1'b0, 1'b1);
    repeat (40) @(negedge clk);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/uart_transceiver.md
# uart_transceiver

Full-duplex, parametrised UART transceiver: one transmitter and one receiver sharing a clock, with a configurable data width, an oversampling baud divider, optional parity and 1 or 2 stop bits. It succeeds the fixed 1-clock-per-bit point-to-point link. It sits between a byte-stream producer/consumer (valid/ready on TX, valid pulse on RX) and the serial pins. Two instances cross-wired (txd→rxd) form the standard loopback link used in system benches.

## Interface
- N, 8: data bits per frame (5..16), LSB first on the line.
- CLKS_PER_BIT, 16: clock cycles per serial bit; must be ≥4.
- PARITY_EN, 0: 1 adds one parity bit after the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1: 1 or 2 stop bits on transmit; the receiver checks only the first.
- clk  in  1  single clock for all logic.
- rst  in  1  reset, synchronous and active-low (rst=0 at a clk edge resets).
- tx_data  in  N  word to send; sampled on accept.
- tx_valid  in  1  a word is offered.
- tx_ready  out  1  transmitter idle; accept = tx_valid & tx_ready.
- txd  out  1  serial output, idle high, registered.
- rxd  in  1  serial input, asynchronous.
- rx_data  out  N  last received word; held until the next frame.
- rx_valid  out  1  one-cycle pulse when a frame completes.
- rx_parity_err  out  1  parity mismatch on last frame; updated with rx_valid.
- rx_frame_err  out  1  stop bit sampled low on last frame; updated with rx_valid.

## Operation
- Reset values: txd=1, tx_ready=1, rx_valid=0, rx_data=0, both error flags 0, both FSMs IDLE, all counters 0.
- TX FSM: IDLE → START → DATA → (PARITY if PARITY_EN) → STOP → IDLE.
  - On accept, latch tx_data into the shift register. tx_ready drops the next cycle.
  - Every state holds txd for exactly CLKS_PER_BIT cycles. START drives 0. DATA drives bits 0..N-1. PARITY drives the XOR of the data, inverted if PARITY_ODD. STOP drives 1 for STOP_BITS bit times.
  - tx_ready rises the cycle after the last stop bit ends.
  - tx_valid while busy is ignored; there is no queuing.
- RX path: rxd passes through a 2-flop synchronizer. The FSM sees only the synchronized signal.
- RX FSM: IDLE → START → DATA → (PARITY) → STOP → IDLE.
  - IDLE waits for a synchronized low.
  - START counts CLKS_PER_BIT/2 (floor) cycles and re-samples. If high, it is a false start: return to IDLE with no output.
  - Each later bit is sampled exactly CLKS_PER_BIT cycles after the previous sample.
  - At the STOP sample: load rx_data, set rx_parity_err (0 if PARITY_EN=0) and rx_frame_err (stop==0), and pulse rx_valid the next cycle.
  - A frame with errors still delivers data and pulses rx_valid.
  - After the stop sample, RX returns to IDLE immediately and can catch a start bit that begins half a bit later.
- TX and RX are fully independent. Simultaneous TX accept and RX completion do not interact.
- Reset mid-frame: both FSMs abort. txd is 1 the cycle after the reset edge. A partial RX frame is discarded with no rx_valid.

## Timing
- Accept to txd falling edge: 1 cycle.
- TX frame length: (1+N+PARITY_EN+STOP_BITS)·CLKS_PER_BIT cycles.
- Accept to tx_ready high again: frame length + 1 cycle.
- Back-to-back throughput: with tx_valid held high, the next accept occurs on the cycle tx_ready rises.
- rxd falling edge to rx_valid: 2 + CLKS_PER_BIT/2 + (N+PARITY_EN+1)·CLKS_PER_BIT + 1 cycles.
  - Defaults give 2+8+144+1 = 155 cycles.
- rx_valid is high for exactly 1 cycle. rx_data and the error flags are stable from that cycle until the next rx_valid.
- All bit-period counters are ⌈log2(CLKS_PER_BIT)⌉ wide and wrap to 0 at CLKS_PER_BIT-1. The bit index counter is ⌈log2(N)⌉ wide.

## Structure
- Shared package uart_pkg holds:
  - tx_state_t and rx_state_t enums.
  - Function frame_bits(N, PARITY_EN, STOP_BITS).
  - Parity helper function.
- One sub-module is natural: uart_bit_timer (counter with load/half-load, tick output), instantiated once in TX and once in RX.
- Target size is 200–300 lines total.

## Test plan
- Loopback with defaults, send 0xA5: rx_data=0xA5, rx_valid pulses 155 cycles after txd falls, both error flags 0.
- PARITY_EN=1, even parity, send 0x2B: parity bit 0 on the line and no error. Repeat with the parity bit forced to 1 on rxd: rx_parity_err=1, rx_data=0x2B.
- Drive a frame for 0x3C with the stop bit held low: rx_valid pulses, rx_data=0x3C, rx_frame_err=1. The next clean frame clears the flag.
- tx_valid held high with 0x11 then 0x22: tx_ready low for 160 cycles per word (N=8, C=16, 1 stop). The second txd start comes 161 cycles after the first. The receiver outputs 0x11 then 0x22.
- rxd low glitch of 4 cycles: no rx_valid and RX back in IDLE; a following 0x5A frame is received correctly.
- rst=0 asserted mid-TX and mid-RX: txd=1 the next cycle, tx_ready=1, no rx_valid. The following 0xC5 exchange succeeds in both directions.
